// File: rtl/fib_stack_engine.sv
// fib_stack_engine: Fibonacci(entry) via an explicit 16x4 stack.
// Controller FSM drives eight strobes; datapath returns four flags.

module fib_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done,
  input  logic backtrack,
  input  logic cal_update,
  input  logic updated,
  output logic load_init,
  output logic push,
  output logic alu,
  output logic updater,
  output logic cal_res,
  output logic dont_check,
  output logic res_updater,
  output logic poping,
  output logic ready
);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    TEST,
    EXPAND,
    CALC,
    WRITE,
    WAIT,
    POP,
    FINISH
  } state_t;

  state_t state;

  // Next state plus the strobes of that state, all registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      load_init   <= 1'b0;
      push        <= 1'b0;
      alu         <= 1'b0;
      updater     <= 1'b0;
      cal_res     <= 1'b0;
      dont_check  <= 1'b0;
      res_updater <= 1'b0;
      poping      <= 1'b0;
      ready       <= 1'b1;
    end else begin
      load_init   <= 1'b0;
      push        <= 1'b0;
      alu         <= 1'b0;
      updater     <= 1'b0;
      cal_res     <= 1'b0;
      dont_check  <= 1'b0;
      res_updater <= 1'b0;
      poping      <= 1'b0;
      ready       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT;
            load_init <= 1'b1;
          end else begin
            ready <= 1'b1;
          end
        end
        INIT: state <= TEST;
        TEST: begin
          if (backtrack) begin
            // cur is stable through CALC, so the leaf
            // choice can be latched here.
            state      <= CALC;
            cal_res    <= cal_update;
            dont_check <= ~cal_update;
          end else begin
            state   <= EXPAND;
            push    <= 1'b1;
            alu     <= 1'b1;
            updater <= 1'b1;
          end
        end
        EXPAND: state <= TEST;
        CALC: begin
          state       <= WRITE;
          res_updater <= 1'b1;
        end
        WRITE: state <= WAIT;
        WAIT: begin
          if (updated) begin
            if (done) begin
              state <= FINISH;
            end else begin
              state  <= POP;
              poping <= 1'b1;
            end
          end
        end
        POP: state <= TEST;
        FINISH: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module fib_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  entry,
  input  logic        load_init,
  input  logic        push,
  input  logic        alu,
  input  logic        updater,
  input  logic        cal_res,
  input  logic        dont_check,
  input  logic        res_updater,
  input  logic        poping,
  output logic        done,
  output logic        backtrack,
  output logic        cal_update,
  output logic        updated,
  output logic [20:0] result
);

  logic [3:0]  cur;
  logic [4:0]  sp;
  logic [20:0] tmp;
  logic [3:0]  stack [16];
  logic [3:0]  push_val;
  logic [3:0]  pop_idx;

  assign push_val   = alu ? cur - 4'd2 : cur - 4'd1;
  assign pop_idx    = sp[3:0] - 4'd1;
  assign done       = (sp == 5'd0);
  assign backtrack  = (cur < 4'd2);
  assign cal_update = (cur == 4'd1);

  // Stack storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp[3:0]] <= push_val;
    end
  end

  // Working registers and the result accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= 4'd0;
      sp      <= 5'd0;
      tmp     <= 21'd0;
      result  <= 21'd0;
      updated <= 1'b0;
    end else if (load_init) begin
      cur     <= entry;
      sp      <= 5'd0;
      tmp     <= 21'd0;
      result  <= 21'd0;
      updated <= 1'b0;
    end else begin
      if (updater) begin
        cur <= cur - 4'd1;
      end else if (poping) begin
        cur <= stack[pop_idx];
      end
      if (push) begin
        sp <= sp + 5'd1;
      end else if (poping) begin
        sp <= sp - 5'd1;
      end
      if (cal_res) begin
        tmp <= result + 21'd1;
      end else if (dont_check) begin
        tmp <= result;
      end
      if (res_updater) begin
        result  <= tmp;
        updated <= 1'b1;
      end else if (poping) begin
        updated <= 1'b0;
      end
    end
  end

endmodule

module fib_stack_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  entry,
  output logic [20:0] result,
  output logic        ready
);

  logic load_init;
  logic push;
  logic alu;
  logic updater;
  logic cal_res;
  logic dont_check;
  logic res_updater;
  logic poping;
  logic done;
  logic backtrack;
  logic cal_update;
  logic updated;

  fib_controller u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .backtrack   (backtrack),
    .cal_update  (cal_update),
    .updated     (updated),
    .load_init   (load_init),
    .push        (push),
    .alu         (alu),
    .updater     (updater),
    .cal_res     (cal_res),
    .dont_check  (dont_check),
    .res_updater (res_updater),
    .poping      (poping),
    .ready       (ready)
  );

  fib_datapath u_dp (
    .clk         (clk),
    .rst         (rst),
    .entry       (entry),
    .load_init   (load_init),
    .push        (push),
    .alu         (alu),
    .updater     (updater),
    .cal_res     (cal_res),
    .dont_check  (dont_check),
    .res_updater (res_updater),
    .poping      (poping),
    .done        (done),
    .backtrack   (backtrack),
    .cal_update  (cal_update),
    .updated     (updated),
    .result      (result)
  );

endmodule

// File: tb/tb_fib_stack_engine.sv
// Bench for fib_stack_engine: scoreboard of expected runs
// from a recursion-count model, monitor checks each completion.

module tb_fib_stack_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  entry;
  logic [20:0] result;
  logic        ready;

  fib_stack_engine dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .entry  (entry),
    .result (result),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int res;
    int cycles;
    int cal;
    int dont;
    int pushes;
    int pops;
    int maxsp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit aborted = 1'b0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Recursion-tree view: leaves = F(n+1), value-1 leaves = F(n).
  function automatic exp_t model(input int n);
    exp_t e;
    int f[18];
    int l;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i < 18; i++) f[i] = f[i-1] + f[i-2];
    l = f[n+1];
    e.n      = n;
    e.res    = f[n];
    e.cycles = 1 + 2*(l-1) + 4*l + (l-1) + 1;
    e.cal    = f[n];
    e.dont   = l - f[n];
    e.pushes = l - 1;
    e.pops   = l - 1;
    e.maxsp  = (n > 0) ? n - 1 : 0;
    return e;
  endfunction

  function automatic int strobes();
    return int'({dut.load_init, dut.push, dut.alu, dut.updater,
                 dut.cal_res, dut.dont_check, dut.res_updater,
                 dut.poping});
  endfunction

  // Monitor: tracks each run from ready falling to ready rising.
  bit running = 1'b0;
  bit prev_ready = 1'b1;
  int cyc, n_cal, n_dont, n_push, n_pop, max_sp, excl_bad;

  always @(negedge clk) begin
    if (!rst || aborted) begin
      running    = 1'b0;
      prev_ready = ready;
    end else begin
      if (running) begin
        cyc++;
        if (dut.cal_res) n_cal++;
        if (dut.dont_check) n_dont++;
        if (dut.push) n_push++;
        if (dut.poping) n_pop++;
        if (int'(dut.u_dp.sp) > max_sp) max_sp = int'(dut.u_dp.sp);
        if (dut.push && dut.poping) excl_bad++;
        if (dut.cal_res && dut.dont_check) excl_bad++;
      end
      if (prev_ready && !ready) begin
        running  = 1'b1;
        cyc      = 0;
        n_cal    = 0;
        n_dont   = 0;
        n_push   = 0;
        n_pop    = 0;
        max_sp   = 0;
        excl_bad = 0;
      end else if (!prev_ready && ready && running) begin
        running = 1'b0;
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: result %0d, none expected",
                   result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("result n=%0d", e.n), result, e.res);
          chk($sformatf("cycles n=%0d", e.n), cyc, e.cycles);
          chk($sformatf("cal_res n=%0d", e.n), n_cal, e.cal);
          chk($sformatf("dont_check n=%0d", e.n), n_dont, e.dont);
          chk($sformatf("push n=%0d", e.n), n_push, e.pushes);
          chk($sformatf("pop n=%0d", e.n), n_pop, e.pops);
          chk($sformatf("max_sp n=%0d", e.n), max_sp, e.maxsp);
          chk($sformatf("exclusive n=%0d", e.n), excl_bad, 0);
        end
      end
      prev_ready = ready;
    end
  end

  task automatic wait_ready(input string name);
    int t = 0;
    while (!ready && t < 8000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      errors++;
      checks++;
      $display("FAIL %s: ready got 0 expected 1 after timeout", name);
    end
  endtask

  task automatic run(input int n, input int hold);
    wait_ready("idle_before");
    sb.push_back(model(n));
    entry = 4'(n);
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_ready($sformatf("done n=%0d", n));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    rst   = 1'b0;
    start = 1'b0;
    entry = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_result", result, 0);
    chk("reset_ready", ready, 1);
    chk("reset_sp", dut.u_dp.sp, 0);
    chk("reset_strobes", strobes(), 0);
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (strobes() != 0 || !ready) bad++;
    end
    chk("idle_quiet", bad, 0);

    run(0, 1);
    run(5, 3);
    run(10, 1);
    run(2, 2);
    run(15, 10);
    repeat (6) run($urandom_range(0, 12), $urandom_range(1, 3));

    // Abort a long run with an asynchronous reset.
    wait_ready("idle_before_abort");
    entry = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    chk("abort_busy", ready, 0);
    aborted = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_ready", ready, 1);
    chk("abort_sp", dut.u_dp.sp, 0);
    chk("abort_strobes", strobes(), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    aborted = 1'b0;
    run(6, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
